// File: rtl/reg_spi_ctrl.sv
// rtl/reg_spi_ctrl.sv - serial (sclk/cs_n/mosi/miso) front end to a bank of DW-bit registers
// Frames: R/W bit, AW address bits, DW data bits, MSB first, sampled on sclk rise.
module reg_spi_ctrl #(
  parameter int DW   = 16,
  parameter int AW   = 4,
  parameter int NREG = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [NREG-1:0]      reg_we,
  output logic [DW-1:0]        reg_data_in,
  input  logic [NREG*DW-1:0]   rd_data,
  output logic                 busy
);

  localparam int MAXB = (AW > DW) ? AW : DW;
  localparam int CW   = ($clog2(MAXB + 1) > 5) ? $clog2(MAXB + 1) : 5;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

  logic [2:0]      sclk_q;
  logic [1:0]      cs_q;
  logic [1:0]      mosi_q;
  logic [1:0]      rel_q;
  logic            cs_arm_q;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rw_q, rw_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wr_sh_q, wr_sh_d;
  logic [DW-1:0]   rd_sh_q, rd_sh_d;
  logic [NREG-1:0] we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            sclk_rise, sclk_fall, cs_sync, mosi_sync, cs_start;
  logic [AW-1:0]   addr_nxt;
  logic [DW-1:0]   wr_nxt;
  logic [DW-1:0]   rd_sel;
  logic [NREG-1:0] we_hot;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_sync   = cs_q[1];
  assign mosi_sync = mosi_q[1];
  // A frame starts only after cs_n was genuinely seen high since reset release,
  // so a cs_n held low across reset cannot fake a falling edge.
  assign cs_start  = cs_arm_q & ~cs_sync;
  assign addr_nxt  = {addr_q[AW-2:0], mosi_sync};
  assign wr_nxt    = {wr_sh_q[DW-2:0], mosi_sync};

  always_comb begin
    rd_sel = '0;
    we_hot = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr_nxt == AW'(i)) rd_sel = rd_data[i*DW +: DW];
      we_hot[i] = (addr_q == AW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wr_sh_d = wr_sh_q;
    rd_sh_d = rd_sh_q;
    we_d    = '0;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (cs_start) begin
          state_d = CMD;
          cnt_d   = '0;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          rw_d    = mosi_sync;
          state_d = ADDR;
          cnt_d   = '0;
        end
      end
      ADDR: begin
        if (sclk_rise) begin
          addr_d = addr_nxt;
          if (cnt_q == CW'(AW - 1)) begin
            state_d = DATA;
            cnt_d   = '0;
            if (!rw_q) rd_sh_d = rd_sel;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DATA: begin
        if (sclk_rise) begin
          if (rw_q) wr_sh_d = wr_nxt;
          if (cnt_q == CW'(DW - 1)) begin
            state_d = DONE;
            // we_hot is all zero for addresses beyond the attached registers
            if (rw_q && (we_hot != '0)) begin
              we_d    = we_hot;
              wdata_d = wr_nxt;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (sclk_fall && !rw_q) begin
          rd_sh_d = {rd_sh_q[DW-2:0], 1'b0};
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    if (cs_sync && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      we_d    = '0;
      wdata_d = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q   <= 3'b000;
      cs_q     <= 2'b11;
      mosi_q   <= 2'b00;
      rel_q    <= 2'b00;
      cs_arm_q <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wr_sh_q  <= '0;
      rd_sh_q  <= '0;
      we_q     <= '0;
      wdata_q  <= '0;
    end else begin
      sclk_q   <= {sclk_q[1:0], sclk};
      cs_q     <= {cs_q[0], cs_n};
      mosi_q   <= {mosi_q[0], mosi};
      rel_q    <= {rel_q[0], 1'b1};
      cs_arm_q <= rel_q[1] & cs_sync;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wr_sh_q  <= wr_sh_d;
      rd_sh_q  <= rd_sh_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

  assign miso        = (state_q == DATA) & ~rw_q & rd_sh_q[DW-1];
  assign busy        = (state_q != IDLE);
  assign reg_we      = we_q;
  assign reg_data_in = wdata_q;

endmodule

// File: tb/tb_reg_spi_ctrl.sv
// tb/tb_reg_spi_ctrl.sv - directed and randomized frames against two reg_spi_ctrl instances (NREG 16 and 12)
module tb_reg_spi_ctrl;

  logic          clk = 1'b0;
  logic          rst_n, sclk, cs_a, cs_b, mosi;
  logic          miso_a, miso_b, busy_a, busy_b;
  logic [15:0]   we_a, wd_a, wd_b;
  logic [11:0]   we_b;
  logic [255:0]  rd_a;
  logic [191:0]  rd_b;
  logic [15:0]   rd_words [16];
  logic [15:0]   model_wd [2];

  int cmp = 0;
  int err = 0;
  int pc_a = 0;
  int pc_b = 0;
  logic [31:0] lw_a = '0;
  logic [31:0] lw_b = '0;

  always #5 clk = ~clk;

  reg_spi_ctrl #(.DW(16), .AW(4), .NREG(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_a), .mosi(mosi), .miso(miso_a),
    .reg_we(we_a), .reg_data_in(wd_a), .rd_data(rd_a), .busy(busy_a));

  reg_spi_ctrl #(.DW(16), .AW(4), .NREG(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_b), .mosi(mosi), .miso(miso_b),
    .reg_we(we_b), .reg_data_in(wd_b), .rd_data(rd_b), .busy(busy_b));

  always @(negedge clk) begin
    if (we_a != '0) begin pc_a++; lw_a = 32'(we_a); end
    if (we_b != '0) begin pc_b++; lw_b = 32'(we_b); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_rd();
    for (int i = 0; i < 16; i++) begin
      rd_words[i] = 16'($urandom);
      rd_a[i*16 +: 16] = rd_words[i];
      if (i < 12) rd_b[i*16 +: 16] = rd_words[i];
    end
  endtask

  // Leaves cs_n low; miso is sampled just before each sclk fall from the last address bit on.
  task automatic frame(input bit b, input bit rw, input logic [3:0] addr, input logic [15:0] data,
                       input int nd, input int extra, input int rst_at, output logic [15:0] mw);
    logic bv;
    mw = '0;
    if (b) cs_b = 1'b0; else cs_a = 1'b0;
    #80;
    for (int i = 0; i < 5 + nd; i++) begin
      if (i == 0) bv = rw;
      else if (i < 5) bv = addr[4-i];
      else bv = data[15-(i-5)];
      if (rst_at >= 0 && i == 5 + rst_at) begin
        rst_n = 1'b0; #10; rst_n = 1'b1;
      end
      mosi = bv; #40; sclk = 1'b1; #80;
      if (i >= 4 && i <= 19) mw[15-(i-4)] = b ? miso_b : miso_a;
      sclk = 1'b0; #40;
    end
    for (int k = 0; k < extra; k++) begin
      mosi = 1'($urandom); #40; sclk = 1'b1; #80; sclk = 1'b0; #40;
    end
  endtask

  task automatic end_frame();
    #40; cs_a = 1'b1; cs_b = 1'b1; #80;
  endtask

  initial begin
    logic [15:0] mw;
    int p0, nreg, nd, extra;
    bit b, rw, ab, exp_pulse;
    logic [3:0] addr;
    logic [15:0] data;

    rst_n = 1'b0; sclk = 1'b0; cs_a = 1'b1; cs_b = 1'b1; mosi = 1'b0;
    model_wd[0] = '0; model_wd[1] = '0;
    load_rd();
    @(negedge clk); #40; rst_n = 1'b1; #100;

    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    chk("rst_we_a", 32'(we_a), 0);
    chk("rst_we_b", 32'(we_b), 0);
    chk("rst_wd_a", 32'(wd_a), 0);
    chk("rst_miso_a", 32'(miso_a), 0);
    chk("rst_miso_b", 32'(miso_b), 0);

    p0 = pc_a;
    frame(0, 1, 4'h3, 16'hA5C3, 16, 0, -1, mw);
    end_frame();
    chk("wr3_pulses", 32'(pc_a - p0), 1);
    chk("wr3_we", lw_a, 32'h0008);
    chk("wr3_data", 32'(wd_a), 32'hA5C3);
    #200;
    chk("wr3_hold", 32'(wd_a), 32'hA5C3);

    rd_words[5] = 16'h1234; rd_a[5*16 +: 16] = 16'h1234; rd_b[5*16 +: 16] = 16'h1234;
    p0 = pc_a;
    frame(0, 0, 4'h5, 16'hFFFF, 16, 0, -1, mw);
    chk("rd5_busy", 32'(busy_a), 1);
    end_frame();
    chk("rd5_miso", 32'(mw), 32'h1234);
    chk("rd5_pulses", 32'(pc_a - p0), 0);
    chk("rd5_miso_idle", 32'(miso_a), 0);

    p0 = pc_a;
    frame(0, 1, 4'h3, 16'h0F0F, 10, 0, -1, mw);
    chk("abort_busy_before", 32'(busy_a), 1);
    cs_a = 1'b1; #40;
    chk("abort_busy_4clk", 32'(busy_a), 0);
    #80;
    chk("abort_pulses", 32'(pc_a - p0), 0);
    chk("abort_wd", 32'(wd_a), 32'hA5C3);

    p0 = pc_b;
    frame(1, 1, 4'hE, 16'hBEEF, 16, 0, -1, mw);
    end_frame();
    chk("b_wrE_pulses", 32'(pc_b - p0), 0);
    chk("b_wrE_wd", 32'(wd_b), 0);
    frame(1, 0, 4'hE, 16'h0000, 16, 0, -1, mw);
    end_frame();
    chk("b_rdE_miso", 32'(mw), 0);

    p0 = pc_a;
    frame(0, 1, 4'h7, 16'h5555, 16, 0, 5, mw);
    chk("rst_mid_busy", 32'(busy_a), 0);
    end_frame();
    chk("rst_mid_pulses", 32'(pc_a - p0), 0);
    chk("rst_mid_wd", 32'(wd_a), 0);
    frame(0, 1, 4'h0, 16'hFFFF, 16, 0, -1, mw);
    end_frame();
    chk("post_rst_pulses", 32'(pc_a - p0), 1);
    chk("post_rst_we", lw_a, 32'h0001);
    chk("post_rst_wd", 32'(wd_a), 32'hFFFF);
    model_wd[0] = 16'hFFFF;

    p0 = pc_a;
    frame(0, 1, 4'h9, 16'h6C3A, 16, 8, -1, mw);
    end_frame();
    chk("extra_pulses", 32'(pc_a - p0), 1);
    chk("extra_we", lw_a, 32'h0200);
    chk("extra_wd", 32'(wd_a), 32'h6C3A);
    model_wd[0] = 16'h6C3A;

    for (int n = 0; n < 24; n++) begin
      load_rd();
      b     = 1'($urandom);
      rw    = 1'($urandom);
      addr  = 4'($urandom);
      data  = 16'($urandom);
      ab    = ($urandom_range(0, 4) == 0);
      nd    = ab ? $urandom_range(0, 15) : 16;
      extra = ab ? 0 : $urandom_range(0, 4);
      nreg  = b ? 12 : 16;
      exp_pulse = rw && !ab && (int'(addr) < nreg);
      p0 = b ? pc_b : pc_a;
      frame(b, rw, addr, data, nd, extra, -1, mw);
      end_frame();
      chk("rnd_pulses", 32'((b ? pc_b : pc_a) - p0), exp_pulse ? 1 : 0);
      if (exp_pulse) begin
        model_wd[b] = data;
        chk("rnd_we", b ? lw_b : lw_a, 32'(1) << addr);
      end
      chk("rnd_wd", 32'(b ? wd_b : wd_a), 32'(model_wd[b]));
      if (!rw && !ab)
        chk("rnd_miso", 32'(mw), (int'(addr) < nreg) ? 32'(rd_words[addr]) : 0);
      chk("rnd_busy_end", 32'(b ? busy_b : busy_a), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
